// File: rtl/exc_ctrl_pkg.sv
// Shared CPU constants for exception handling: cause codes, vector layout
// and the address helpers used by the exception controller.
package exc_ctrl_pkg;

    localparam logic [1:0] CAUSE_IRQ = 2'd0;
    localparam logic [1:0] CAUSE_SYS = 2'd1;
    localparam logic [1:0] CAUSE_BRK = 2'd2;

    localparam int VEC_STRIDE = 16;
    localparam int VEC_SHIFT  = 4;
    localparam int IVT_SHIFT  = 10;

    // Vector = IVT base page plus one 16-byte slot per cause code.
    function automatic logic [31:0] vec_addr(input logic [21:0] ivt, input logic [1:0] cause);
        return (32'(ivt) << IVT_SHIFT) | (32'(cause) << VEC_SHIFT);
    endfunction

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Redirect handshake between the exception controller and instruction fetch.
interface exc_ctrl_if;
    logic        o_redir_valid;
    logic [31:0] o_redir_addr;
    logic        i_redir_ack;

    modport master (output o_redir_valid, output o_redir_addr, input i_redir_ack);
    modport slave  (input o_redir_valid, input o_redir_addr, output i_redir_ack);
endinterface

// File: rtl/exc_ctrl_sync_ff.sv
// Multi-flop synchronizer for a level signal crossing into the clk domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: takes SYSCALL/BREAK/IRQ at writeback, flushes the
// pipeline and holds a redirect to the vector until fetch acknowledges it.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_exec_stall,
    input  logic        i_mem_stall,
    input  logic        i_fetch_stall,
    input  logic        i_irq,
    input  logic        i_valid_p3,
    input  logic [31:0] i_pc_p3,
    input  logic        i_bd_p3,
    input  logic        i_sys_p3,
    input  logic        i_brk_p3,
    input  logic        i_rfe_p3,
    input  logic        i_sr_ie,
    input  logic [21:0] i_ivt,
    exc_ctrl_if.master  redir_if,
    output logic        o_exc_entry,
    output logic [31:0] o_epc,
    output logic [1:0]  o_cause,
    output logic        o_bd,
    output logic        o_drop_p1,
    output logic        o_drop_p2,
    output logic        o_drop_p3,
    output logic        o_busy
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       irq_s;
    logic       core_stall;
    logic       sync_exc;
    logic       irq_take;
    logic       redir_valid;
    logic [31:0] redir_addr;
    logic       drop;

    sync_ff #(.STAGES(IRQ_SYNC_STAGES)) u_irq_sync (
        .clk  (clk),
        .nrst (nrst),
        .d_i  (i_irq),
        .q_o  (irq_s)
    );

    assign core_stall = i_exec_stall | i_mem_stall | i_fetch_stall;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cause_q <= CAUSE_IRQ;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        sync_exc    = 1'b0;
        irq_take    = 1'b0;
        o_exc_entry = 1'b0;
        o_epc       = '0;
        o_cause     = CAUSE_IRQ;
        o_bd        = 1'b0;
        drop        = 1'b0;
        redir_valid = 1'b0;
        redir_addr  = '0;
        unique case (state_q)
            IDLE: begin
                // nrst gating keeps the combinational take path quiet during reset.
                if (nrst && !core_stall && i_valid_p3) begin
                    sync_exc = i_sys_p3 | i_brk_p3;
                    irq_take = irq_s & i_sr_ie & ~i_rfe_p3 & ~sync_exc;
                    if (sync_exc || irq_take) begin
                        o_exc_entry = 1'b1;
                        drop        = 1'b1;
                        o_bd        = i_bd_p3;
                        o_epc       = epc_of(i_pc_p3, i_bd_p3);
                        o_cause     = i_sys_p3 ? CAUSE_SYS : (i_brk_p3 ? CAUSE_BRK : CAUSE_IRQ);
                        cause_d     = o_cause;
                        state_d     = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                drop        = 1'b1;
                redir_valid = 1'b1;
                redir_addr  = vec_addr(i_ivt, cause_q);
                if (redir_if.i_redir_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_drop_p1              = drop;
    assign o_drop_p2              = drop;
    assign o_drop_p3              = drop;
    assign o_busy                 = (state_q == REDIRECT);
    assign redir_if.o_redir_valid = redir_valid;
    assign redir_if.o_redir_addr  = redir_addr;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a behavioural model of the exception rules.
module tb_exc_ctrl;

    localparam int NS = 2;

    logic        clk;
    logic        nrst;
    logic        exec_stall, mem_stall, fetch_stall;
    logic        irq;
    logic        valid_p3;
    logic [31:0] pc_p3;
    logic        bd_p3, sys_p3, brk_p3, rfe_p3;
    logic        sr_ie;
    logic [21:0] ivt;
    logic        exc_entry;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        bd;
    logic        drop_p1, drop_p2, drop_p3;
    logic        busy;

    exc_ctrl_if rif();

    exc_ctrl #(.IRQ_SYNC_STAGES(NS)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .i_exec_stall  (exec_stall),
        .i_mem_stall   (mem_stall),
        .i_fetch_stall (fetch_stall),
        .i_irq         (irq),
        .i_valid_p3    (valid_p3),
        .i_pc_p3       (pc_p3),
        .i_bd_p3       (bd_p3),
        .i_sys_p3      (sys_p3),
        .i_brk_p3      (brk_p3),
        .i_rfe_p3      (rfe_p3),
        .i_sr_ie       (sr_ie),
        .i_ivt         (ivt),
        .redir_if      (rif.master),
        .o_exc_entry   (exc_entry),
        .o_epc         (epc),
        .o_cause       (cause),
        .o_bd          (bd),
        .o_drop_p1     (drop_p1),
        .o_drop_p2     (drop_p2),
        .o_drop_p3     (drop_p3),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Model state: whether a redirect is outstanding, its cause, and the
    // i_irq level seen at each of the last NS clock edges (index 0 newest).
    bit       m_redir;
    int       m_cause;
    bit       irq_seen [NS];

    // One clock: check outputs against the model mid-cycle, then advance it.
    task automatic cycle();
        bit          e_entry, e_bd, e_drop, e_rv, e_busy, take, nxt_redir, irq_now;
        logic [31:0] e_epc, e_ra;
        int          e_cause, nxt_cause;
        @(negedge clk);
        #1;
        e_entry = 0; e_bd = 0; e_drop = 0; e_rv = 0; e_busy = 0; take = 0;
        e_epc = 0; e_ra = 0; e_cause = 0;
        nxt_redir = m_redir; nxt_cause = m_cause;
        irq_now = irq;
        if (!nrst) begin
            nxt_redir = 0; nxt_cause = 0;
        end else if (m_redir) begin
            e_rv = 1; e_drop = 1; e_busy = 1;
            e_ra = ivt * 1024 + m_cause * 16;
            if (rif.i_redir_ack) nxt_redir = 0;
        end else if (!(exec_stall || mem_stall || fetch_stall) && valid_p3) begin
            if (sys_p3)      begin take = 1; e_cause = 1; end
            else if (brk_p3) begin take = 1; e_cause = 2; end
            else if (irq_seen[NS-1] && sr_ie && !rfe_p3) begin take = 1; e_cause = 0; end
            if (take) begin
                e_entry = 1; e_drop = 1; e_bd = bd_p3;
                e_epc = bd_p3 ? pc_p3 - 4 : pc_p3;
                nxt_redir = 1; nxt_cause = e_cause;
            end
        end
        chk("exc_entry", exc_entry, e_entry);
        chk("epc", epc, e_epc);
        chk("cause", cause, e_cause);
        chk("bd", bd, e_bd);
        chk("drops", {drop_p1, drop_p2, drop_p3}, {3{e_drop}});
        chk("redir_valid", rif.o_redir_valid, e_rv);
        chk("redir_addr", rif.o_redir_addr, e_ra);
        chk("busy", busy, e_busy);
        @(posedge clk);
        m_redir = nxt_redir;
        m_cause = nxt_cause;
        if (!nrst) begin
            for (int i = 0; i < NS; i++) irq_seen[i] = 0;
        end else begin
            for (int i = NS - 1; i > 0; i--) irq_seen[i] = irq_seen[i-1];
            irq_seen[0] = irq_now;
        end
        #1;
    endtask

    task automatic quiet();
        valid_p3 = 0; sys_p3 = 0; brk_p3 = 0; rfe_p3 = 0; bd_p3 = 0;
        exec_stall = 0; mem_stall = 0; fetch_stall = 0;
    endtask

    // Return to a clean IDLE with the synchronizer drained.
    task automatic flush();
        quiet();
        irq = 0;
        rif.i_redir_ack = 1;
        repeat (NS + 2) cycle();
        rif.i_redir_ack = 0;
    endtask

    initial begin
        nrst = 0; irq = 0; sr_ie = 0; ivt = 22'h4; pc_p3 = 0;
        rif.i_redir_ack = 0;
        quiet();
        m_redir = 0; m_cause = 0;
        for (int i = 0; i < NS; i++) irq_seen[i] = 0;
        #1;
        repeat (2) cycle();
        chk("reset_busy", busy, 0);
        chk("reset_rv", rif.o_redir_valid, 0);
        nrst = 1;
        cycle();

        // SYSCALL at writeback
        valid_p3 = 1; sys_p3 = 1; pc_p3 = 32'h1000; ivt = 22'h4;
        #1;
        chk("sys_entry", exc_entry, 1);
        chk("sys_epc", epc, 32'h1000);
        chk("sys_cause", cause, 1);
        cycle();
        quiet();
        #1;
        chk("sys_vec", rif.o_redir_addr, 32'h0000_1010);
        repeat (5) begin
            #1 chk("hold_rv", rif.o_redir_valid, 1);
            chk("hold_drop", drop_p1, 1);
            cycle();
        end
        rif.i_redir_ack = 1;
        cycle();
        rif.i_redir_ack = 0;
        #1 chk("ack_idle", busy, 0);
        cycle();

        // IRQ on a delay-slot instruction, seen after NS edges
        irq = 1; sr_ie = 1; valid_p3 = 1; pc_p3 = 32'h200; bd_p3 = 1;
        #1 chk("irq_wait0", exc_entry, 0);
        cycle();
        #1 chk("irq_wait1", exc_entry, 0);
        cycle();
        #1;
        chk("irq_entry", exc_entry, 1);
        chk("irq_epc", epc, 32'h1FC);
        chk("irq_bd", bd, 1);
        chk("irq_cause", cause, 0);
        cycle();
        quiet();
        #1 chk("irq_vec", rif.o_redir_addr, 32'h1000);
        flush();

        // Masked IRQ stays pending; taken once unmasked and unstalled
        irq = 1; sr_ie = 0; valid_p3 = 1; pc_p3 = 32'h300;
        repeat (10) begin
            #1 chk("masked", exc_entry, 0);
            cycle();
        end
        sr_ie = 1; exec_stall = 1;
        #1 chk("unmask_stall", exc_entry, 0);
        cycle();
        exec_stall = 0;
        #1 chk("unmask_take", exc_entry, 1);
        chk("unmask_cause", cause, 0);
        cycle();
        flush();

        // IRQ alongside BREAK: BREAK first, IRQ right after the ack
        irq = 1; sr_ie = 1;
        repeat (NS) cycle();
        valid_p3 = 1; brk_p3 = 1; pc_p3 = 32'h500;
        #1 chk("brk_cause", cause, 2);
        cycle();
        brk_p3 = 0; rif.i_redir_ack = 1;
        cycle();
        rif.i_redir_ack = 0;
        #1 chk("irq_after_brk", exc_entry, 1);
        chk("irq_after_brk_c", cause, 0);
        cycle();
        flush();

        // RFE blocks a pending IRQ for one cycle
        irq = 1; sr_ie = 1;
        repeat (NS) cycle();
        valid_p3 = 1; rfe_p3 = 1;
        #1 chk("rfe_block", exc_entry, 0);
        cycle();
        rfe_p3 = 0; sr_ie = 0;
        #1 chk("rfe_masked", exc_entry, 0);
        cycle();
        flush();

        // SYSCALL+BREAK together, then a stalled take
        valid_p3 = 1; sys_p3 = 1; brk_p3 = 1; pc_p3 = 32'h600;
        #1 chk("sysbrk_cause", cause, 1);
        cycle();
        quiet();
        #1 chk("sysbrk_vec", rif.o_redir_addr, 32'h1010);
        flush();
        valid_p3 = 1; sys_p3 = 1; mem_stall = 1; pc_p3 = 32'h400;
        #1 chk("stall0", exc_entry, 0);
        cycle();
        pc_p3 = 32'h404;
        cycle();
        mem_stall = 0; pc_p3 = 32'h408;
        #1 chk("stall_release", exc_entry, 1);
        chk("stall_epc", epc, 32'h408);
        cycle();

        // Reset pulse in the middle of a redirect
        quiet();
        #1 chk("pre_rst_busy", busy, 1);
        nrst = 0;
        #1;
        chk("rst_rv", rif.o_redir_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_p3, 0);
        cycle();
        nrst = 1;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            exec_stall  = ($urandom_range(0, 9) == 0);
            mem_stall   = ($urandom_range(0, 9) == 0);
            fetch_stall = ($urandom_range(0, 14) == 0);
            valid_p3    = ($urandom_range(0, 4) != 0);
            pc_p3       = $urandom;
            bd_p3       = $urandom_range(0, 1);
            sys_p3      = ($urandom_range(0, 19) == 0);
            brk_p3      = ($urandom_range(0, 19) == 0);
            rfe_p3      = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 14) == 0) sr_ie = ~sr_ie;
            if ($urandom_range(0, 19) == 0) irq = ~irq;
            if ($urandom_range(0, 49) == 0) ivt = $urandom;
            rif.i_redir_ack = ($urandom_range(0, 2) == 0);
            nrst = ($urandom_range(0, 299) != 0);
            cycle();
        end
        nrst = 1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter IRQ_SYNC_STAGES, default 2, number of flops synchronizing i_irq (legal 2..4).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- i_exec_stall / i_mem_stall / i_fetch_stall  in  1 each  core stall sources; core_stall = OR of all three
- i_irq  in  1  external interrupt, level, asynchronous to clk
- i_valid_p3  in  1  writeback-stage slot holds a real instruction
- i_pc_p3  in  32  PC of writeback-stage instruction
- i_bd_p3  in  1  writeback instruction is in a branch delay slot
- i_sys_p3 / i_brk_p3  in  1 each  SYSCALL / BREAK in writeback
- i_rfe_p3  in  1  RFE in writeback
- i_sr_ie  in  1  IE flag from coprocessor 0 Status
- i_ivt  in  22  IVT base, high 22 bits
- i_redir_ack  in  1  fetch accepted the redirect
- o_exc_entry  out  1  one-cycle pulse: coprocessor 0 saves EPC, PSR_IE<=SR_IE, SR_IE<=0
- o_epc  out  32  EPC value, valid with o_exc_entry
- o_cause  out  2  0=IRQ, 1=SYSCALL, 2=BREAK, valid with o_exc_entry
- o_bd  out  1  exception taken on a delay-slot instruction, valid with o_exc_entry
- o_drop_p1 / o_drop_p2 / o_drop_p3  out  1 each  flush decode / execute / writeback
- o_redir_valid  out  1  redirect request to fetch
- o_redir_addr  out  32  redirect target
- o_busy  out  1  state != IDLE

Function
REQ-003 SHALL implement FSM IDLE -> REDIRECT -> IDLE; reset state IDLE.
REQ-004 SHALL pass i_irq through IRQ_SYNC_STAGES flops; irq_s = last stage.
REQ-005 In IDLE with !core_stall and i_valid_p3, sync_exc = i_sys_p3 | i_brk_p3; irq_take = irq_s & i_sr_ie & !i_rfe_p3 & !sync_exc.
REQ-006 Priority: SYSCALL > BREAK > IRQ; a masked IRQ stays pending while level-high, nothing is latched.
REQ-007 On take (same cycle, combinational): o_exc_entry=1; o_drop_p1/p2/p3=1; o_cause per REQ-006; o_bd=i_bd_p3; o_epc = i_bd_p3 ? i_pc_p3-4 : i_pc_p3 (32-bit modulo).
REQ-008 Taking instruction does not retire (dropped at p3); EPC points to it, or to its branch when in a delay slot.
REQ-009 On take, register cause; next state REDIRECT.
REQ-010 In REDIRECT: o_redir_valid=1; o_redir_addr = {i_ivt, 10'b0} | {cause, 4'b0000}; o_drop_p1/p2/p3 held 1; o_exc_entry=0.
REQ-011 REDIRECT -> IDLE in the cycle i_redir_ack=1 (o_redir_valid high that cycle); core_stall has no effect in REDIRECT.
REQ-012 No exception evaluation in REDIRECT; first new take possible the cycle after return to IDLE.
REQ-013 In IDLE with core_stall=1 or i_valid_p3=0: no take, all outputs 0.
REQ-014 i_rfe_p3 with pending IRQ: IRQ blocked that cycle, evaluated next cycle against the updated i_sr_ie.
REQ-015 i_sys_p3 and i_brk_p3 both high (illegal): cause=SYSCALL.
REQ-016 o_busy = (state == REDIRECT).

Reset
REQ-017 nrst low SHALL asynchronously force state IDLE, cause 0, synchronizer flops 0, all outputs 0, including mid-REDIRECT.
REQ-018 After nrst release, IRQ take requires IRQ_SYNC_STAGES clk edges of i_irq high.

Structure
REQ-019 Cause codes, vector stride (16 bytes), IVT shift (10) SHALL be constants in the shared CPU constants include; FSM state encodings local.
REQ-020 SHALL instantiate one sub-module sync_ff (IRQ_SYNC_STAGES-deep synchronizer); rest in exc_ctrl.

Verification
REQ-021 i_sys_p3=1, i_pc_p3=0x0000_1000, i_bd_p3=0, i_ivt=0x000004 -> o_exc_entry pulse, o_epc=0x1000, o_cause=1, then o_redir_addr=0x0000_1010 until ack.
REQ-022 i_irq=1, i_sr_ie=1, i_pc_p3=0x200, i_bd_p3=1 -> take after 2 cycles (default), o_epc=0x1FC, o_bd=1, o_cause=0, o_redir_addr=i_ivt<<10.
REQ-023 i_irq=1 with i_sr_ie=0 for 10 cycles -> no take; raise i_sr_ie -> take next valid non-stalled cycle.
REQ-024 i_irq=1 and i_brk_p3=1 same cycle -> o_cause=2; IRQ taken in first IDLE cycle after ack with i_sr_ie=1.
REQ-025 i_redir_ack held 0 for 5 cycles -> o_redir_valid and drops held 5+ cycles; ack -> IDLE next cycle; nrst pulse mid-REDIRECT -> all outputs 0 immediately.
REQ-026 Take condition with i_mem_stall=1 -> no take until stall drops, then take with then-current i_pc_p3.
